full_adder_2ha: RTL and testbench

//   Registered binary adder: Sum/Carry = a + b + c, built from half-adder cells.

---
 rtl/full_adder_2ha_pkg.sv | 11 +
 rtl/full_adder_2ha_half_adder.sv | 13 +
 rtl/full_adder_2ha.sv | 89 ++++++++
 tb/tb_full_adder_2ha.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/full_adder_2ha_pkg.sv
// Shared constants for the half-adder based ripple adder.
// Holds the default parameter values and the reset values of the output register.
package full_adder_2ha_pkg;

  localparam int unsigned DEFAULT_WIDTH   = 1;
  localparam bit          DEFAULT_OUT_REG = 1'b1;

  localparam logic RESET_CARRY = 1'b0;
  localparam logic RESET_VALID = 1'b0;

endpackage

// File: rtl/full_adder_2ha_half_adder.sv
// Half adder cell: s = a ^ b, co = a & b.
// Two of these cells plus an OR gate form one full-adder bit of the ripple chain.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic co
);

  assign s  = a ^ b;
  assign co = a & b;

endmodule

// File: rtl/full_adder_2ha.sv
// Ripple-carry adder {Carry, Sum} = a + b + c built from half-adder cells,
// with an optional output register stage (OUT_REG=1 gives latency 1).
module full_adder_2ha
  import full_adder_2ha_pkg::*;
#(
  parameter int unsigned WIDTH   = DEFAULT_WIDTH,
  parameter bit          OUT_REG = DEFAULT_OUT_REG
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic             out_valid,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry
);

  // Handshake: in_valid qualifies a/b/c in the cycle it is high; there is no
  // ready, so an operand is accepted every cycle. out_valid marks the cycle in
  // which Sum/Carry carry the result of a qualified input.

  logic [WIDTH-1:0] sum_comb;
  logic             carry_comb;

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
    logic cin;
    logic cout;
    logic s0;
    logic c0;
    logic c1;

    if (i == 0) begin : g_first
      assign cin = c;
    end else begin : g_rest
      assign cin = g_cell[i-1].cout;
    end

    half_adder u_ha0 (.a(a[i]), .b(b[i]), .s(s0), .co(c0));
    half_adder u_ha1 (.a(s0), .b(cin), .s(sum_comb[i]), .co(c1));

    assign cout = c0 | c1;
  end

  assign carry_comb = g_cell[WIDTH-1].cout;

  if (OUT_REG) begin : g_reg
    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] sum_q;
    logic             carry_d;
    logic             carry_q;
    logic             valid_d;
    logic             valid_q;

    // Idle cycles keep the last result so downstream logic never sees X.
    always_comb begin
      sum_d   = sum_q;
      carry_d = carry_q;
      valid_d = 1'b0;
      if (in_valid) begin
        sum_d   = sum_comb;
        carry_d = carry_comb;
        valid_d = 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        sum_q   <= '0;
        carry_q <= RESET_CARRY;
        valid_q <= RESET_VALID;
      end else begin
        sum_q   <= sum_d;
        carry_q <= carry_d;
        valid_q <= valid_d;
      end
    end

    assign Sum       = sum_q;
    assign Carry     = carry_q;
    assign out_valid = valid_q;
  end else begin : g_comb
    assign Sum       = sum_comb;
    assign Carry     = carry_comb;
    assign out_valid = in_valid & ~rst;
  end

endmodule

// File: tb/tb_full_adder_2ha.sv
// Self-checking bench for full_adder_2ha: registered WIDTH=1/8/16 instances and
// a combinational WIDTH=1 instance, compared against plain arithmetic a+b+c.
module tb_full_adder_2ha;

  logic clk;
  logic rst;

  // WIDTH=1, registered
  logic       v1, a1, b1, c1;
  logic       ov1;
  logic [0:0] s1;
  logic       co1;

  // WIDTH=8, registered
  logic       v8, c8;
  logic [7:0] a8, b8;
  logic       ov8;
  logic [7:0] s8;
  logic       co8;

  // WIDTH=1, combinational, own reset
  logic       rstc, vc, ac, bc, cc;
  logic       ovc;
  logic [0:0] sc;
  logic       coc;

  // WIDTH=16, registered
  logic        v16, c16;
  logic [15:0] a16, b16;
  logic        ov16;
  logic [15:0] s16;
  logic        co16;

  int pass_cnt = 0;
  int total    = 0;

  logic [31:0] exp_q[$];

  full_adder_2ha #(.WIDTH(1), .OUT_REG(1'b1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .c(c1),
    .out_valid(ov1), .Sum(s1), .Carry(co1)
  );

  full_adder_2ha #(.WIDTH(8), .OUT_REG(1'b1)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8), .c(c8),
    .out_valid(ov8), .Sum(s8), .Carry(co8)
  );

  full_adder_2ha #(.WIDTH(1), .OUT_REG(1'b0)) u_comb (
    .clk(clk), .rst(rstc), .in_valid(vc), .a(ac), .b(bc), .c(cc),
    .out_valid(ovc), .Sum(sc), .Carry(coc)
  );

  full_adder_2ha #(.WIDTH(16), .OUT_REG(1'b1)) u_w16 (
    .clk(clk), .rst(rst), .in_valid(v16), .a(a16), .b(b16), .c(c16),
    .out_valid(ov16), .Sum(s16), .Carry(co16)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference: {valid, carry-out, sum} of an unsigned add of width w.
  function automatic logic [31:0] ref_add(input int w, input logic vld,
                                          input longint x, input longint y, input longint ci);
    longint full;
    full = x + y + ci;
    full = full & ((64'sd1 <<< (w + 1)) - 1);
    return 32'((longint'(vld) <<< (w + 1)) | full);
  endfunction

  initial begin
    int          k;
    int          ta, tb, tc;
    logic [31:0] last16;
    logic        vv;
    logic [31:0] got;

    rst = 1'b1;
    v1 = 0; a1 = 0; b1 = 0; c1 = 0;
    v8 = 0; a8 = 0; b8 = 0; c8 = 0;
    rstc = 0; vc = 0; ac = 0; bc = 0; cc = 0;
    v16 = 0; a16 = 0; b16 = 0; c16 = 0;

    repeat (2) @(negedge clk);
    check("reset_w1", 32'({ov1, co1, s1}), 32'h0);
    check("reset_w8", 32'({ov8, co8, s8}), 32'h0);
    check("reset_w16", 32'({ov16, co16, s16}), 32'h0);
    rst = 1'b0;

    // Exhaustive truth table, one vector per cycle, result one cycle later
    for (k = 0; k < 8; k++) begin
      ta = (k >> 2) & 1; tb = (k >> 1) & 1; tc = k & 1;
      a1 = ta[0]; b1 = tb[0]; c1 = tc[0]; v1 = 1'b1;
      exp_q.push_back(ref_add(1, 1'b1, ta, tb, tc));
      @(negedge clk);
      check($sformatf("exh_%0d", k), 32'({ov1, co1, s1}), exp_q.pop_front());
    end

    // Hold: last result 111 -> S1C1 must persist while idle
    v1 = 1'b0; a1 = 0; b1 = 0; c1 = 0;
    @(negedge clk);
    check("hold_0", 32'({ov1, co1, s1}), 32'b011);
    @(negedge clk);
    check("hold_1", 32'({ov1, co1, s1}), 32'b011);

    // Reset with inputs held at 111 and valid
    a1 = 1; b1 = 1; c1 = 1; v1 = 1'b1; rst = 1'b1;
    @(negedge clk);
    check("rst_cyc0", 32'({ov1, co1, s1}), 32'h0);
    @(negedge clk);
    check("rst_cyc1", 32'({ov1, co1, s1}), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_release", 32'({ov1, co1, s1}), 32'b111);

    // Reset mid-stream drops the input presented in the reset cycle
    a1 = 1; b1 = 1; c1 = 0; v1 = 1'b1;
    @(negedge clk);
    check("mid_before", 32'({ov1, co1, s1}), ref_add(1, 1'b1, 1, 1, 0));
    a1 = 1; b1 = 0; c1 = 1; rst = 1'b1;
    @(negedge clk);
    check("mid_dropped", 32'({ov1, co1, s1}), 32'h0);
    rst = 1'b0; v1 = 1'b0;
    @(negedge clk);
    check("mid_after", 32'({ov1, co1, s1}), 32'h0);

    // WIDTH=8 boundary vectors
    a8 = 8'hFF; b8 = 8'h01; c8 = 1'b0; v8 = 1'b1;
    @(negedge clk);
    check("w8_ff_01", 32'({ov8, co8, s8}), ref_add(8, 1'b1, 'hFF, 'h01, 0));
    a8 = 8'h7F; b8 = 8'h80; c8 = 1'b1;
    @(negedge clk);
    check("w8_7f_80_c", 32'({ov8, co8, s8}), {22'd0, 1'b1, 1'b1, 8'h00});
    a8 = 8'h12; b8 = 8'h34; c8 = 1'b1;
    @(negedge clk);
    check("w8_12_34_c", 32'({ov8, co8, s8}), {22'd0, 1'b1, 1'b0, 8'h47});
    v8 = 1'b0; a8 = 8'h00; b8 = 8'h00; c8 = 1'b0;
    @(negedge clk);
    check("w8_hold", 32'({ov8, co8, s8}), {22'd0, 1'b0, 1'b0, 8'h47});

    // Combinational instance: results follow inputs without any clock edge
    for (k = 0; k < 8; k++) begin
      ta = (k >> 2) & 1; tb = (k >> 1) & 1; tc = k & 1;
      ac = ta[0]; bc = tb[0]; cc = tc[0]; vc = 1'b1;
      #1;
      check($sformatf("comb_%0d", k), 32'({ovc, coc, sc}), ref_add(1, 1'b1, ta, tb, tc));
      #99;
    end
    rstc = 1'b1;
    #1;
    check("comb_rst", 32'({ovc, coc, sc}), ref_add(1, 1'b0, 1, 1, 1));
    rstc = 1'b0; vc = 1'b0;
    #1;
    check("comb_idle", 32'({ovc, coc, sc}), ref_add(1, 1'b0, 1, 1, 1));

    // Random WIDTH=16 stream with occasional idle cycles
    @(negedge clk);
    last16 = 32'h0;
    for (k = 0; k < 1000; k++) begin
      vv  = ($urandom_range(0, 3) != 0);
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      c16 = 1'($urandom_range(0, 1));
      v16 = vv;
      if (vv) last16 = ref_add(16, 1'b0, longint'(a16), longint'(b16), longint'(c16));
      exp_q.push_back(last16 | (32'(vv) << 17));
      @(negedge clk);
      got = 32'({ov16, co16, s16});
      check($sformatf("rand16_%0d", k), got, exp_q.pop_front());
    end
    v16 = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
